// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 5-stage CPU datapath.
//
//   Contents:
//     fwd_sel_e   - forwarding-mux select codes produced by fwd_unit
//     CTRL_*      - bit positions inside the 5-bit decoded control word
//                   {alu_src, reg_write, mem_read, mem_write, mem_to_reg}
//     alu_ctrl_e  - ALU control codes {ainvert, bnegate, op[1:0]}
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Forwarding source for one ALU operand.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,  // value read from the register file in ID
    FWD_MEMWB = 2'b01,  // value about to be written back by MEM/WB
    FWD_EXMEM = 2'b10   // ALU result of the instruction in EX/MEM
  } fwd_sel_e;

  // Decoded control word layout.
  localparam int CTRL_W          = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  // ALU control word width and codes.
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  // A bubble: no register write, no memory access, ALU doing AND.
  localparam logic [CTRL_W-1:0]     CTRL_BUBBLE     = '0;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_BUBBLE = ALU_AND;

endpackage : cpu_pkg

// File: rtl/fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
//   Forwarding decision for a single source register. Compares the source
//   address held in ID/EX against the destinations of the two younger
//   pipeline stages and reports which value the operand mux should take.
//
//   Ports:
//     src              in   WIDTH_R  source register address (registered rs/rt)
//     exmem_reg_write  in   1        EX/MEM instruction writes a register
//     exmem_rd         in   WIDTH_R  EX/MEM destination
//     memwb_reg_write  in   1        MEM/WB instruction writes a register
//     memwb_rd         in   WIDTH_R  MEM/WB destination
//     sel              out  2        FWD_EXMEM / FWD_MEMWB / FWD_REG
// ---------------------------------------------------------------------------
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH_R = 5
) (
  input  logic [WIDTH_R-1:0] src,
  input  logic               exmem_reg_write,
  input  logic [WIDTH_R-1:0] exmem_rd,
  input  logic               memwb_reg_write,
  input  logic [WIDTH_R-1:0] memwb_rd,
  output fwd_sel_e           sel
);

  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hard-wired to zero, so a "write" to it must never be
  // forwarded even if the producing instruction asserted reg_write.
  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

  // EX/MEM holds the younger result, so it takes priority when both match.
  always_comb begin
    sel = FWD_REG;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule : fwd_unit

// File: rtl/id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_stage
//   ID/EX pipeline register with operand forwarding, feeding the ALU.
//
//   Each rising clock edge the decoded operands and control from ID are
//   captured, unless the stage is reset (all zero), flushed (bubble, all
//   zero) or stalled (hold). Priority: rst > flush > stall > load.
//   The ALU operands are then resolved combinationally from the registered
//   rs/rt against the EX/MEM and MEM/WB destinations, so forwarding keeps
//   tracking the younger stages even while this stage is stalled.
//
//   Ports:
//     clk, rst            in   1        clock; synchronous active-high reset
//     stall, flush        in   1        hold contents / load a bubble
//     id_rs_data          in   WIDTH_D  register-file rs read data
//     id_rt_data          in   WIDTH_D  register-file rt read data
//     id_imm              in   WIDTH_D  sign-extended immediate
//     id_rs, id_rt        in   WIDTH_R  source addresses
//     id_rd               in   WIDTH_R  destination address
//     id_alu_ctrl         in   4        {ainvert, bnegate, op[1:0]}
//     id_ctrl             in   5        {alu_src, reg_write, mem_read,
//                                        mem_write, mem_to_reg}
//     exmem_reg_write/rd/result  in     EX/MEM forwarding source
//     memwb_reg_write/rd/result  in     MEM/WB forwarding source
//     ex_alu_ctrl         out  4        registered ALU control
//     ex_ctrl             out  5        registered control word
//     ex_rd               out  WIDTH_R  registered destination
//     alu_a               out  WIDTH_D  forwarded rs
//     alu_b               out  WIDTH_D  registered imm or forwarded rt
//     ex_store_data       out  WIDTH_D  forwarded rt (store data)
// ---------------------------------------------------------------------------
module id_ex_fwd_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH_D = 32,
  parameter int WIDTH_R = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [WIDTH_D-1:0]    id_rs_data,
  input  logic [WIDTH_D-1:0]    id_rt_data,
  input  logic [WIDTH_D-1:0]    id_imm,
  input  logic [WIDTH_R-1:0]    id_rs,
  input  logic [WIDTH_R-1:0]    id_rt,
  input  logic [WIDTH_R-1:0]    id_rd,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  exmem_reg_write,
  input  logic [WIDTH_R-1:0]    exmem_rd,
  input  logic [WIDTH_D-1:0]    exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [WIDTH_R-1:0]    memwb_rd,
  input  logic [WIDTH_D-1:0]    memwb_result,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [WIDTH_R-1:0]    ex_rd,
  output logic [WIDTH_D-1:0]    alu_a,
  output logic [WIDTH_D-1:0]    alu_b,
  output logic [WIDTH_D-1:0]    ex_store_data
);

  // Number of forwarded source operands (rs -> index 0, rt -> index 1).
  localparam int NUM_SRC = 2;
  localparam int SRC_RS  = 0;
  localparam int SRC_RT  = 1;

  // -------------------------------------------------------------------------
  // ID/EX register bank
  // -------------------------------------------------------------------------
  logic [WIDTH_D-1:0]    rs_data_reg,  rs_data_next;
  logic [WIDTH_D-1:0]    rt_data_reg,  rt_data_next;
  logic [WIDTH_D-1:0]    imm_reg,      imm_next;
  logic [WIDTH_R-1:0]    rs_reg,       rs_next;
  logic [WIDTH_R-1:0]    rt_reg,       rt_next;
  logic [WIDTH_R-1:0]    rd_reg,       rd_next;
  logic [ALU_CTRL_W-1:0] alu_ctrl_reg, alu_ctrl_next;
  logic [CTRL_W-1:0]     ctrl_reg,     ctrl_next;

  // Next-state selection: flush beats stall, stall beats a normal load.
  // Reset is handled in the register process and beats everything.
  always_comb begin
    // Default: hold (covers the stall case).
    rs_data_next  = rs_data_reg;
    rt_data_next  = rt_data_reg;
    imm_next      = imm_reg;
    rs_next       = rs_reg;
    rt_next       = rt_reg;
    rd_next       = rd_reg;
    alu_ctrl_next = alu_ctrl_reg;
    ctrl_next     = ctrl_reg;

    if (flush) begin
      // Bubble: clearing rs/rt as well as ctrl means the squashed slot can
      // never pick up a forwarded value either.
      rs_data_next  = '0;
      rt_data_next  = '0;
      imm_next      = '0;
      rs_next       = '0;
      rt_next       = '0;
      rd_next       = '0;
      alu_ctrl_next = ALU_CTRL_BUBBLE;
      ctrl_next     = CTRL_BUBBLE;
    end else if (!stall) begin
      rs_data_next  = id_rs_data;
      rt_data_next  = id_rt_data;
      imm_next      = id_imm;
      rs_next       = id_rs;
      rt_next       = id_rt;
      rd_next       = id_rd;
      alu_ctrl_next = id_alu_ctrl;
      ctrl_next     = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data_reg  <= '0;
      rt_data_reg  <= '0;
      imm_reg      <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      alu_ctrl_reg <= ALU_CTRL_BUBBLE;
      ctrl_reg     <= CTRL_BUBBLE;
    end else begin
      rs_data_reg  <= rs_data_next;
      rt_data_reg  <= rt_data_next;
      imm_reg      <= imm_next;
      rs_reg       <= rs_next;
      rt_reg       <= rt_next;
      rd_reg       <= rd_next;
      alu_ctrl_reg <= alu_ctrl_next;
      ctrl_reg     <= ctrl_next;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding: one decision unit and one 3:1 data mux per source operand.
  // -------------------------------------------------------------------------
  logic [WIDTH_R-1:0] src_addr [NUM_SRC];
  logic [WIDTH_D-1:0] src_data [NUM_SRC];
  logic [WIDTH_D-1:0] fwd_data [NUM_SRC];
  fwd_sel_e           fwd_sel  [NUM_SRC];

  assign src_addr[SRC_RS] = rs_reg;
  assign src_addr[SRC_RT] = rt_reg;
  assign src_data[SRC_RS] = rs_data_reg;
  assign src_data[SRC_RT] = rt_data_reg;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      fwd_unit #(
        .WIDTH_R (WIDTH_R)
      ) u_fwd_unit (
        .src             (src_addr[gi]),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (fwd_sel[gi])
      );

      assign fwd_data[gi] = (fwd_sel[gi] == FWD_EXMEM) ? exmem_result :
                            (fwd_sel[gi] == FWD_MEMWB) ? memwb_result :
                                                         src_data[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ex_alu_ctrl   = alu_ctrl_reg;
  assign ex_ctrl       = ctrl_reg;
  assign ex_rd         = rd_reg;
  assign alu_a         = fwd_data[SRC_RS];
  assign ex_store_data = fwd_data[SRC_RT];
  // The immediate is a constant of the instruction itself; it is never
  // forwarded, only the rt path is.
  assign alu_b         = ctrl_reg[CTRL_ALU_SRC] ? imm_reg : fwd_data[SRC_RT];

endmodule : id_ex_fwd_stage
